// File: rtl/cpu_pkg.sv
// Shared constants, opcode/state encodings and opcode legality helper
// for the instruction-fetch stage.
package cpu_pkg;

  localparam int AW    = 7;   // PC / instruction-memory address width
  localparam int DW    = 16;  // instruction width
  localparam int OP_LO = 8;   // lowest bit of the opcode field
  localparam int OPW   = DW - OP_LO;

  typedef enum logic [OPW-1:0] {
    OP_CLA = 8'd0,
    OP_COM = 8'd1,
    OP_SHR = 8'd2,
    OP_CSL = 8'd3,
    OP_STP = 8'd4,
    OP_ADD = 8'd5,
    OP_STA = 8'd6,
    OP_LDA = 8'd7,
    OP_JMP = 8'd8,
    OP_BAN = 8'd9
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HALT
  } fetch_state_t;

  // An opcode is legal only when fully known and within CLA..BAN.
  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    if ($isunknown(op)) return 1'b0;
    return (op <= OP_BAN);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port plus the IR valid/ready handshake toward the
// decoder. The fetch unit takes the master side.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_ins;
  logic          ir_valid;
  logic          ir_ready;
  logic [DW-1:0] ir_out;
  logic [AW-1:0] ir_pc;

  modport master (
    output mem_addr, ir_valid, ir_out, ir_pc,
    input  mem_ins, ir_ready
  );

  modport slave (
    input  mem_addr, ir_valid, ir_out, ir_pc,
    output mem_ins, ir_ready
  );

endinterface

// File: rtl/pc_counter.sv
// Program counter: load has priority over increment, otherwise hold.
// Increment wraps naturally modulo 2^AW.
module pc_counter
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic          inc_i,
  output logic [AW-1:0] pc_o
);

  logic [AW-1:0] pc_q, pc_d;

  // Next-PC selection.
  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_addr_i;
    else if (inc_i) pc_d = pc_q + AW'(1);
  end

  // PC register with synchronous reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives memory address from the PC, latches the
// returned word into the IR, offers it downstream over valid/ready, accepts
// branch redirects, and halts on STP or an illegal opcode.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          run_en,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_addr,
  output logic          halted,
  output logic          illegal_op,
  fetch_unit_if.master  bus
);

  fetch_state_t  state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          ir_valid_q, ir_valid_d;
  logic          illegal_q, illegal_d;
  logic          pc_load, pc_inc;
  logic [AW-1:0] pc;
  logic [OPW-1:0] op;
  logic          op_legal;

  pc_counter u_pc (
    .clk         (clk),
    .rst         (rst),
    .load_i      (pc_load),
    .load_addr_i (redirect_addr),
    .inc_i       (pc_inc),
    .pc_o        (pc)
  );

  assign op       = bus.mem_ins[DW-1:OP_LO];
  assign op_legal = is_legal_op(op);

  // Next-state and IR update logic.
  // NOTE: every signal gets its hold value first, so no branch can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    illegal_d  = illegal_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_en) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          // Flush wins even over a same-cycle consume.
          pc_load    = 1'b1;
          ir_valid_d = 1'b0;
        end else if (run_en && (!ir_valid_q || bus.ir_ready)) begin
          ir_d       = bus.mem_ins;
          ir_pc_d    = pc;
          ir_valid_d = 1'b1;
          pc_inc     = 1'b1;
          if (!op_legal || op == OP_STP) state_d   = ST_HALT;
          if (!op_legal)                 illegal_d = 1'b1;
        end else if (bus.ir_ready) begin
          ir_valid_d = 1'b0;
        end
      end
      ST_HALT: begin
        // Only the held IR drains; PC and redirects are frozen out.
        if (bus.ir_ready) ir_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and IR registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.mem_addr = pc;
  assign bus.ir_valid = ir_valid_q;
  assign bus.ir_out   = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign halted       = (state_q == ST_HALT);
  assign illegal_op   = illegal_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the 7-bit-address, 16-bit-word instruction memory.
- Holds the program counter, drives the memory address combinationally and latches the returned word into an instruction register (IR).
- Presents the IR to the downstream decoder/controller over a valid/ready handshake.
- Accepts branch redirects (JMP/BAN) from execute and halts on STP or an illegal opcode.

Parameters:
- AW, 7, PC / instruction-memory address width.
- DW, 16, instruction width.
- OP_LO, 8, lowest bit of the opcode field; the opcode is ins[DW-1:OP_LO] and the operand is ins[OP_LO-1:0].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- run_en  in  1  level; fetch permitted while high.
- mem_addr  out  AW  address to instruction memory; equals pc (combinational).
- mem_ins  in  DW  word returned combinationally by instruction memory for mem_addr.
- ir_valid  out  1  IR holds an instruction not yet consumed.
- ir_ready  in  1  downstream accepts the IR this cycle.
- ir_out  out  DW  instruction register.
- ir_pc  out  AW  address the IR word was fetched from.
- redirect_valid  in  1  execute requests a PC change (taken JMP/BAN).
- redirect_addr  in  AW  branch target.
- halted  out  1  fetch stopped by STP or an illegal opcode.
- illegal_op  out  1  sticky; opcode > 9 or opcode contains X/Z.

Behaviour:
- Reset values: pc=0, ir_valid=0, ir_out=0, ir_pc=0, halted=0, illegal_op=0, state=IDLE. Reset wins over every other input in any state, including mid-handshake.
- States: IDLE, FETCH, HALT.
- IDLE: no loads. Moves to FETCH on the first cycle run_en=1.
- FETCH, load condition: run_en=1 and (ir_valid=0 or ir_ready=1) and redirect_valid=0.
- FETCH, on load: ir_out<=mem_ins, ir_pc<=pc, ir_valid<=1, pc<=pc+1 (modulo 2^AW, so 127 wraps to 0). Latency: word at address A appears on ir_out one cycle after pc=A.
- FETCH, consume without load (ir_ready=1 and run_en=0): ir_valid<=0.
- FETCH, no load and no consume: IR and pc hold (backpressure; pc does not advance).
- Redirect has priority in FETCH: pc<=redirect_addr, ir_valid<=0 (flush, even if ir_ready=1 that cycle), no load. Fetch resumes from the target the next cycle.
- STP (opcode 4) loaded: the IR is loaded normally, pc still increments, and the state moves to HALT with halted=1 on the next cycle.
- Illegal opcode loaded: same as STP, plus illegal_op<=1.
- HALT: no further loads. pc frozen. Redirects ignored. The IR already held is still offered and drains normally (ir_valid clears on ir_ready). Only rst leaves HALT.
- run_en dropping in FETCH stalls loads only; the state stays FETCH.
- Opcode values: CLA 0, COM 1, SHR 2, CSL 3, STP 4, ADD 5, STA 6, LDA 7, JMP 8, BAN 9.

Decomposition:
- Shared package cpu_pkg: AW/DW/OP_LO constants, the opcode enum (CLA..BAN), fetch state enum, and an is_legal_op function.
- One natural sub-module: pc_counter (load / increment / hold, with wrap).

Test Plan:
- Fetch stream: rst 2 cycles, then run_en=1, ir_ready=1, memory model returns addr*256+0x000A.
  -> ir_out=0x000A, 0x010A, 0x020A, 0x030A on consecutive cycles with ir_pc 0..3.
  -> ir_out=0x040A (STP), then halted=1, pc frozen at 5, ir_valid drops after consumption.
- Backpressure: hold ir_ready=0 for 3 cycles while ir_out=0x010A.
  -> ir_out, ir_pc and pc stay constant.
  -> the cycle ir_ready returns to 1, ir_out becomes 0x020A.
- Redirect: with ir_valid=1 holding 0x020A, assert redirect_valid with redirect_addr=8.
  -> next cycle ir_valid=0.
  -> following cycle ir_out=0x080A, ir_pc=8.
- Wrap-around: memory returns 0x000A everywhere; redirect to 127.
  -> ir_pc=127, then ir_pc=0 on the next load.
- Illegal opcode: memory returns 16'hFF00 at address 3.
  -> ir_out=0xFF00, then illegal_op=1 and halted=1. Subsequent redirects are ignored.
- Reset mid-operation: assert rst while in HALT with ir_valid=1.
  -> next cycle all outputs are at reset values and state is IDLE.
  -> after run_en=1, fetch restarts from address 0.
